gray_stream_checker: RTL

//   Receive end of the gray_counter output: samples a free-running Gray-code

---
 rtl/gray_stream_checker.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/gray_stream_checker.sv
// gray_stream_checker
// Samples a Gray-coded counter stream, decodes each valid sample to binary and
// checks that every new value is exactly one count ahead of the previous one.
// Lock, wrap-around, step-error pulses and a saturating error count are
// reported, all registered with one cycle of latency from the sample edge.
//
// Handshake: gray_valid qualifies gray_in for one cycle. There is no
// backpressure. Each valid sample produces exactly one bin_valid pulse on the
// following edge. Cycles with gray_valid=0 change nothing except that the
// pulse outputs return to 0 and clr_err still clears err_count.
module gray_stream_checker #(
   parameter int WIDTH    = 8,
   parameter int LOCK_LEN = 4,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             gray_valid,
   input  logic             clr_err,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             locked,
   output logic             step_err,
   output logic             wrap,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       state_dbg
);

   localparam logic [1:0] ST_ACQUIRE = 2'd0;
   localparam logic [1:0] ST_VERIFY  = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   localparam int               CNT_W    = (LOCK_LEN < 1) ? 1 : $clog2(LOCK_LEN + 1);
   localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_LEN);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;
   localparam logic [WIDTH-1:0] BIN_MAX  = '1;

   // Registered state
   logic [1:0]       state_q,    state_d;
   logic [WIDTH-1:0] prev_q,     prev_d;
   logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
   logic [WIDTH-1:0] bin_out_q,  bin_out_d;
   logic             bin_valid_q, bin_valid_d;
   logic             locked_q,   locked_d;
   logic             step_err_q, step_err_d;
   logic             wrap_q,     wrap_d;
   logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;

   // Combinational decode of the incoming sample
   logic [WIDTH-1:0] new_bin;
   logic [WIDTH-1:0] delta;
   logic             is_good;
   logic             is_hold;
   logic             is_wrap;
   logic [CNT_W-1:0] cnt_inc;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      new_bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         new_bin[i] = ^(gray_in >> i);
      end
   end

   // Step classification against the previous reference (mod 2^WIDTH).
   always_comb begin
      delta   = new_bin - prev_q;
      is_good = (delta == WIDTH'(1));
      is_hold = (delta == '0);
      is_wrap = is_good && (prev_q == BIN_MAX) && (new_bin == '0);
      cnt_inc = good_cnt_q + CNT_W'(1);
   end

   // Next-state logic: FSM, reference tracking, flags and error count.
   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      good_cnt_d  = good_cnt_q;
      bin_out_d   = bin_out_q;
      bin_valid_d = 1'b0;
      locked_d    = locked_q;
      step_err_d  = 1'b0;
      wrap_d      = 1'b0;
      err_cnt_d   = err_cnt_q;

      if (gray_valid) begin
         bin_out_d   = new_bin;
         bin_valid_d = 1'b1;
         prev_d      = new_bin;

         case (state_q)
            ST_ACQUIRE: begin
               // First sample only establishes the reference.
               good_cnt_d = '0;
               state_d    = ST_VERIFY;
            end
            ST_VERIFY: begin
               if (is_good) begin
                  wrap_d     = is_wrap;
                  good_cnt_d = cnt_inc;
                  if (cnt_inc >= LOCK_CNT) begin
                     state_d  = ST_LOCKED;
                     locked_d = 1'b1;
                  end
               end else if (!is_hold) begin
                  // Bad step before lock just restarts the run, silently.
                  good_cnt_d = '0;
               end
            end
            ST_LOCKED: begin
               if (is_good) begin
                  wrap_d = is_wrap;
               end else if (!is_hold) begin
                  step_err_d = 1'b1;
                  locked_d   = 1'b0;
                  good_cnt_d = '0;
                  state_d    = ST_VERIFY;
                  if (err_cnt_q != ERR_MAX) begin
                     err_cnt_d = err_cnt_q + ERR_W'(1);
                  end
               end
            end
            default: begin
               state_d    = ST_ACQUIRE;
               good_cnt_d = '0;
               locked_d   = 1'b0;
            end
         endcase
      end

      // Clear acts on every cycle and wins over a same-cycle increment.
      if (clr_err) begin
         err_cnt_d = '0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ACQUIRE;
         prev_q      <= '0;
         good_cnt_q  <= '0;
         bin_out_q   <= '0;
         bin_valid_q <= 1'b0;
         locked_q    <= 1'b0;
         step_err_q  <= 1'b0;
         wrap_q      <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         good_cnt_q  <= good_cnt_d;
         bin_out_q   <= bin_out_d;
         bin_valid_q <= bin_valid_d;
         locked_q    <= locked_d;
         step_err_q  <= step_err_d;
         wrap_q      <= wrap_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bin_out   = bin_out_q;
   assign bin_valid = bin_valid_q;
   assign locked    = locked_q;
   assign step_err  = step_err_q;
   assign wrap      = wrap_q;
   assign err_count = err_cnt_q;
   assign state_dbg = state_q;

endmodule
